// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module : id_pkg
// Brief  : Shared types and constants for the instruction-dispatch stage:
//          decoded instruction record, execution-unit encoding and the
//          reserved "no producer" ROB tag.
// Rev    : 1.0  initial release
// ============================================================================
package id_pkg;

  // Architectural register index width (up to 32 registers).
  localparam int REG_W = 5;

  // Execution units. The top encoding is reserved for undecodable
  // instructions, which are dropped instead of dispatched.
  localparam int         EX_UNIT_NUM = 3;
  localparam logic [1:0] EX_ALU      = 2'd0;
  localparam logic [1:0] EX_MUL      = 2'd1;
  localparam logic [1:0] EX_LSU      = 2'd2;
  localparam logic [1:0] EX_ERR_UNIT = 2'd3;

  // ROB tag 0 means "value is architectural / already available".
  localparam int TAG_INVALID = 0;

  typedef struct packed {
    logic [5:0]       op;
    logic [1:0]       ex_unit;
    logic [REG_W-1:0] rd;
    logic             rd_en;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [1:0]       rs_en;    // [0] enables rs1, [1] enables rs2
    logic [31:0]      imm;
    logic             imm_en;   // src2 comes from imm
    logic [31:0]      pc;
    logic             pc_en;    // src1 comes from pc
    logic             stall;    // control transfer: block later issue
  } decoded_t;

  function automatic logic is_err_unit(input logic [1:0] unit);
    return unit == EX_ERR_UNIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_tag_table.sv
`default_nettype none
// ============================================================================
// Module : id_tag_table
// Brief  : Register rename table. Holds, per architectural register, the ROB
//          tag of its youngest in-flight producer (TAG_INVALID if none).
//          Register 0 always reads TAG_INVALID.
// Ports  : clk, rst (async)   clock / reset
//          flush              synchronous clear of every entry
//          rd_addr1/2, rd_tag1/2  ISSUE_W pairs of combinational lookups
//          wr_en/addr/tag     ISSUE_W rename writes (higher index wins)
//          wb_valid, wb_tag   completion broadcast, clears matching entries
// Config : ID_WB_BYPASS_EN - lookups hit by the current broadcast tag read
//          as TAG_INVALID in the same cycle.
// Rev    : 1.0  initial release
// ============================================================================
module id_tag_table
  import id_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic [ISSUE_W-1:0][REG_W-1:0]     rd_addr1,
  input  logic [ISSUE_W-1:0][REG_W-1:0]     rd_addr2,
  output logic [ISSUE_W-1:0][TAG_W-1:0]     rd_tag1,
  output logic [ISSUE_W-1:0][TAG_W-1:0]     rd_tag2,
  input  logic [ISSUE_W-1:0]                wr_en,
  input  logic [ISSUE_W-1:0][REG_W-1:0]     wr_addr,
  input  logic [ISSUE_W-1:0][TAG_W-1:0]     wr_tag,
  input  logic                              wb_valid,
  input  logic [TAG_W-1:0]                  wb_tag
);

  localparam logic [TAG_W-1:0] C_TAG_NONE = TAG_W'(TAG_INVALID);

  logic [TAG_W-1:0] r_tab [NREG];
  logic [TAG_W-1:0] w_nxt [NREG];

  function automatic logic [TAG_W-1:0] lookup(input logic [REG_W-1:0] addr);
    logic [TAG_W-1:0] t;
    t = (addr == '0) ? C_TAG_NONE : r_tab[addr];
`ifdef ID_WB_BYPASS_EN
    if (wb_valid && (t == wb_tag)) t = C_TAG_NONE;
`endif
    return t;
  endfunction

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_rd
    assign rd_tag1[k] = lookup(rd_addr1[k]);
    assign rd_tag2[k] = lookup(rd_addr2[k]);
  end

  // Completion clear first, then rename writes in slot order so a
  // same-edge rename overrides the clear and the youngest slot wins.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_nxt[r] = r_tab[r];
      if (wb_valid && (r_tab[r] == wb_tag)) w_nxt[r] = C_TAG_NONE;
      for (int k = 0; k < ISSUE_W; k++)
        if (wr_en[k] && (wr_addr[k] == REG_W'(r))) w_nxt[r] = wr_tag[k];
      if (r == 0) w_nxt[r] = C_TAG_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) r_tab[r] <= C_TAG_NONE;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) r_tab[r] <= C_TAG_NONE;
    end else begin
      for (int r = 0; r < NREG; r++) r_tab[r] <= w_nxt[r];
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_dispatch.sv
`default_nettype none
// ============================================================================
// Module : id_dispatch
// Brief  : In-order instruction queue with superscalar rename/dispatch.
//          Up to ISSUE_W decoded instructions are enqueued per cycle; up to
//          ISSUE_W are dispatched per cycle from the head, each receiving a
//          ROB tag and renamed source tags.
// Ports  : clk, rst (async), rst_tag (sync flush)
//          in_cnt/in_inst/in_ready      enqueue side
//          rob_free/rob_tail/rob_alloc  ROB tag allocation
//          rs_full                      per-unit reservation-station full
//          wb_valid/wb_tag              completion broadcast
//          jump_reset/jump_stall        control-transfer stall handshake
//          dis_valid/dis_inst/dis_tag1/dis_tag2/dis_target  dispatch side
// Config : ID_WB_BYPASS_EN - source tags matching the current broadcast
//          read as TAG_INVALID in the same cycle (see id_tag_table).
// Rev    : 1.0  initial release
// ============================================================================
module id_dispatch
  import id_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int QDEPTH  = 8,
  parameter int NREG    = 32,
  parameter int TAG_W   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rst_tag,
  input  logic [$clog2(ISSUE_W+1)-1:0]        in_cnt,
  input  decoded_t [ISSUE_W-1:0]              in_inst,
  output logic                                in_ready,
  input  logic [TAG_W:0]                      rob_free,
  input  logic [TAG_W-1:0]                    rob_tail,
  output logic [$clog2(ISSUE_W+1)-1:0]        rob_alloc,
  input  logic [EX_UNIT_NUM-1:0]              rs_full,
  input  logic                                wb_valid,
  input  logic [TAG_W-1:0]                    wb_tag,
  input  logic                                jump_reset,
  output logic                                jump_stall,
  output logic [ISSUE_W-1:0]                  dis_valid,
  output decoded_t [ISSUE_W-1:0]              dis_inst,
  output logic [ISSUE_W-1:0][TAG_W-1:0]       dis_tag1,
  output logic [ISSUE_W-1:0][TAG_W-1:0]       dis_tag2,
  output logic [ISSUE_W-1:0][TAG_W-1:0]       dis_target
);

  localparam int               CNT_W      = $clog2(ISSUE_W+1);
  localparam int               PTR_W      = $clog2(QDEPTH);
  localparam logic [TAG_W-1:0] C_TAG_MAX  = '1;
  localparam logic [TAG_W-1:0] C_TAG_NONE = TAG_W'(TAG_INVALID);

  // Queue storage and bookkeeping
  decoded_t         r_q [QDEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_jump_stall;

  decoded_t [ISSUE_W-1:0]            w_slot;
  logic [ISSUE_W-1:0]                w_dis_valid;
  logic [ISSUE_W-1:0]                w_drop;
  logic [ISSUE_W-1:0]                w_wr_en;
  logic [ISSUE_W-1:0]                w_stall_bit;
  logic [ISSUE_W-1:0][TAG_W-1:0]     w_target;
  logic [ISSUE_W-1:0][TAG_W-1:0]     w_tbl1;
  logic [ISSUE_W-1:0][TAG_W-1:0]     w_tbl2;
  logic [ISSUE_W-1:0][TAG_W-1:0]     w_src1;
  logic [ISSUE_W-1:0][TAG_W-1:0]     w_src2;
  logic [ISSUE_W-1:0][REG_W-1:0]     w_rs1;
  logic [ISSUE_W-1:0][REG_W-1:0]     w_rs2;
  logic [ISSUE_W-1:0][REG_W-1:0]     w_rd;
  logic [CNT_W-1:0]                  w_ndis;
  logic [CNT_W-1:0]                  w_nconsume;
  logic [CNT_W-1:0]                  w_nenq;

  assign in_ready = ((PTR_W+1)'(QDEPTH) - r_count) >= (PTR_W+1)'(ISSUE_W);

  // Offers beyond the issue width are clamped; nothing lands while full or
  // while the queue is being flushed.
  assign w_nenq = (!in_ready || rst_tag)      ? '0 :
                  (in_cnt > CNT_W'(ISSUE_W))  ? CNT_W'(ISSUE_W) : in_cnt;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_slot
    assign w_slot[k]      = r_q[r_head + PTR_W'(k)];
    assign w_rs1[k]       = w_slot[k].rs1;
    assign w_rs2[k]       = w_slot[k].rs2;
    assign w_rd[k]        = w_slot[k].rd;
    assign w_stall_bit[k] = w_slot[k].stall;
    assign w_wr_en[k]     = w_dis_valid[k] & w_slot[k].rd_en & (w_slot[k].rd != '0);
  end

  // In-order issue scan. `chain` drops as soon as a slot cannot go, so
  // every later slot is held. An error-unit entry at the end of the chain
  // is consumed without a tag and also ends the scan.
  always_comb begin
    logic                   chain;
    logic                   busy;
    logic [EX_UNIT_NUM-1:0] used;
    chain       = !r_jump_stall && !rst_tag;
    used        = '0;
    w_dis_valid = '0;
    w_drop      = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      busy = 1'b0;
      for (int u = 0; u < EX_UNIT_NUM; u++)
        if (w_slot[k].ex_unit == 2'(u)) busy = rs_full[u] | used[u];
      if (chain && ((PTR_W+1)'(k) < r_count)) begin
        if (is_err_unit(w_slot[k].ex_unit)) begin
          w_drop[k] = 1'b1;
          chain     = 1'b0;
        end else if (((TAG_W+1)'(k) < rob_free) && !busy) begin
          w_dis_valid[k] = 1'b1;
          for (int u = 0; u < EX_UNIT_NUM; u++)
            if (w_slot[k].ex_unit == 2'(u)) used[u] = 1'b1;
          if (w_slot[k].stall) chain = 1'b0;
        end else begin
          chain = 1'b0;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  // Consecutive ROB tags, skipping the reserved tag on wrap.
  always_comb begin
    logic [TAG_W-1:0] t;
    t = rob_tail;
    for (int k = 0; k < ISSUE_W; k++) begin
      w_target[k] = t;
      t = (t == C_TAG_MAX) ? TAG_W'(1) : t + TAG_W'(1);
    end
  end

  always_comb begin
    w_ndis     = '0;
    w_nconsume = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (w_dis_valid[k])             w_ndis     = w_ndis + CNT_W'(1);
      if (w_dis_valid[k] | w_drop[k]) w_nconsume = w_nconsume + CNT_W'(1);
    end
  end

  id_tag_table #(
    .ISSUE_W (ISSUE_W),
    .NREG    (NREG),
    .TAG_W   (TAG_W)
  ) u_tag_table (
    .clk      (clk),
    .rst      (rst),
    .flush    (rst_tag),
    .rd_addr1 (w_rs1),
    .rd_addr2 (w_rs2),
    .rd_tag1  (w_tbl1),
    .rd_tag2  (w_tbl2),
    .wr_en    (w_wr_en),
    .wr_addr  (w_rd),
    .wr_tag   (w_target),
    .wb_valid (wb_valid),
    .wb_tag   (wb_tag)
  );

  // Source renaming: the youngest earlier same-cycle producer overrides
  // the table, since the table does not see this cycle's writes yet.
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      w_src1[k] = w_tbl1[k];
      w_src2[k] = w_tbl2[k];
      for (int j = 0; j < k; j++) begin
        if (w_wr_en[j] && (w_slot[j].rd == w_slot[k].rs1)) w_src1[k] = w_target[j];
        if (w_wr_en[j] && (w_slot[j].rd == w_slot[k].rs2)) w_src2[k] = w_target[j];
      end
      if (!w_slot[k].rs_en[0] || w_slot[k].pc_en)  w_src1[k] = C_TAG_NONE;
      if (!w_slot[k].rs_en[1] || w_slot[k].imm_en) w_src2[k] = C_TAG_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rst_tag) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_nconsume);
      r_tail  <= r_tail + PTR_W'(w_nenq);
      r_count <= r_count + (PTR_W+1)'(w_nenq) - (PTR_W+1)'(w_nconsume);
    end
  end

  // Payload storage needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    for (int j = 0; j < ISSUE_W; j++)
      if (CNT_W'(j) < w_nenq) r_q[r_tail + PTR_W'(j)] <= in_inst[j];
  end

  // Release has priority over a coincident new stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jump_stall <= 1'b0;
    end else if (rst_tag || jump_reset) begin
      r_jump_stall <= 1'b0;
    end else if (|(w_dis_valid & w_stall_bit)) begin
      r_jump_stall <= 1'b1;
    end
  end

  assign jump_stall = r_jump_stall;
  assign rob_alloc  = w_ndis;
  assign dis_valid  = w_dis_valid;
  assign dis_inst   = w_slot;
  assign dis_target = w_target;
  assign dis_tag1   = w_src1;
  assign dis_tag2   = w_src2;

endmodule
`default_nettype wire

// File: doc/id_dispatch.md
ID_DISPATCH -- requirements
Module: id_dispatch

Interface
REQ-001 Parameter ISSUE_W, default 2, max instructions enqueued/dispatched per cycle (1..4).
REQ-002 Parameter QDEPTH, default 8, instruction-queue entries (power of 2, >= 2*ISSUE_W).
REQ-003 Parameter NREG, default 32, architectural registers; TAG_W, default 4, ROB tag width.
REQ-004 One clock, clk; reset rst is asynchronous, active-high.
REQ-005 Ports: clk in 1, clock; rst in 1, async reset; rst_tag in 1, synchronous flush.
REQ-006 in_cnt in clog2(ISSUE_W+1), number of valid instructions offered; in_inst in ISSUE_W x decoded_t, offered instructions; in_ready out 1, queue free >= ISSUE_W.
REQ-007 rob_free in TAG_W+1, free ROB entries; rob_tail in TAG_W, next ROB tag; rob_alloc out clog2(ISSUE_W+1), tags consumed this cycle.
REQ-008 rs_full in EX_UNIT_NUM, reservation-station full per unit.
REQ-009 wb_valid in 1; wb_tag in TAG_W, broadcast tag completing this cycle.
REQ-010 jump_reset in 1, releases jump stall; jump_stall out 1, stall held.
REQ-011 dis_valid out ISSUE_W; dis_inst out ISSUE_W x decoded_t; dis_tag1/dis_tag2 out ISSUE_W x TAG_W, source tags; dis_target out ISSUE_W x TAG_W, assigned ROB tag.

Function
REQ-012 Enqueue: when in_ready, in_cnt entries (slot 0 first) written to queue tail at clk edge; in_cnt ignored when in_ready=0.
REQ-013 Dispatch combinational from queue head, in order: slot k valid only if slots 0..k-1 valid, k < occupancy, k < rob_free, rs_full[ex_unit]=0, no earlier slot this cycle targets same ex_unit, and no earlier slot this cycle has stall=1.
REQ-014 ex_unit == EX_ERR_UNIT: not dispatched, no tag allocated; entry dropped silently from head, counted as consumed.
REQ-015 dis_target[k] = rob_tail + k, wrapping 2^TAG_W-1 -> 1 (tag 0 = TAG_INVALID never assigned); rob_alloc = dispatched count.
REQ-016 Tag table: NREG x TAG_W, reset TAG_INVALID; reg 0 always TAG_INVALID.
REQ-017 Source tag k: TAG_INVALID if rs_en=0 or pc_en (src1) or imm_en (src2); else youngest earlier same-cycle slot writing that rs (rd_en, rd!=0) supplies its dis_target; else table entry.
REQ-018 At edge: each dispatched rd_en slot writes table[rd] = dis_target; youngest slot wins on same rd.
REQ-019 wb_valid: every table entry equal to wb_tag cleared to TAG_INVALID; a same-edge dispatch write to that register takes priority.
REQ-020 Dispatched instruction with stall=1 sets jump_stall next cycle; while set, dis_valid = 0; jump_reset clears it (jump_reset wins if coincident with new set).
REQ-021 Queue full: in_ready=0; empty: dis_valid=0; pointers wrap mod QDEPTH; simultaneous enqueue and dispatch allowed.
REQ-022 rst_tag: queue emptied, table cleared, jump_stall cleared at edge; dis_valid forced 0 that cycle; enqueue that cycle discarded.

Reset
REQ-023 rst: queue empty, pointers 0, table all TAG_INVALID, jump_stall 0; dis_valid 0, rob_alloc 0, in_ready 1 while asserted.

Configuration
REQ-024 ID_WB_BYPASS_EN defined: source tag equal to wb_tag during wb_valid output as TAG_INVALID same cycle; undefined: old tag output, cleared one cycle later.

Structure
REQ-025 Package id_pkg holds decoded_t (op, ex_unit, rd, rd_en, rs1, rs2, rs_en[2], imm, imm_en, pc, pc_en, stall), TAG_INVALID, EX_ERR_UNIT, EX_UNIT_NUM.
REQ-026 One sub-module id_tag_table (lookup, rename write, wb clear, flush); queue and dispatch logic in id_dispatch.

Verification
REQ-027 ISSUE_W=2: r1=r2+r3, r4=r1+r5 same cycle, rob_tail=5 -> targets 5,6; slot1 dis_tag1=5.
REQ-028 rob_tail=15, 2 dispatched -> targets 15,1; rob_alloc=2.
REQ-029 Two ALU ops, rs_full[ALU]=0 -> only slot0 dispatches; slot1 dispatches next cycle.
REQ-030 Branch (stall=1) in slot0 -> slot1 held, jump_stall=1 until jump_reset pulse, then resumes.
REQ-031 table[r7]=9, wb_tag=9 and lookup of r7 same cycle -> dis_tag 0 with ID_WB_BYPASS_EN, 9 without; table 0 after.
REQ-032 Queue full with 8 entries, rst_tag -> next cycle empty, in_ready=1, all tags TAG_INVALID.
